// File: rtl/ann_pkg.sv
// Shared types and derived constants for the approximate-nearest-neighbour engine.
package ann_pkg;

  localparam int DATA_WIDTH  = 11;
  localparam int DIST_WIDTH  = 25;
  localparam int IDX_WIDTH   = 9;
  localparam int LEAF_SIZE   = 8;
  localparam int PATCH_SIZE  = 5;
  localparam int NUM_QUERYS  = 494;
  localparam int NUM_LEAVES  = 64;
  localparam int LEAF_ADDRW  = 6;

  localparam int NUM_NODES   = NUM_LEAVES - 1;
  localparam int LEAF_WORDS  = LEAF_SIZE * (PATCH_SIZE + 1);
  localparam int QUERY_WORDS = NUM_QUERYS * PATCH_SIZE;
  localparam int NUM_PATCHES = NUM_LEAVES * LEAF_SIZE;

  localparam int NODE_AW  = $clog2(NUM_NODES);
  localparam int NODE_W   = LEAF_ADDRW + 1;
  localparam int PATCH_AW = $clog2(NUM_PATCHES);
  localparam int QIDX_W   = $clog2(NUM_QUERYS);
  localparam int MAJOR_W  = (PATCH_AW > QIDX_W) ? PATCH_AW : QIDX_W;
  localparam int MINOR_W  = $clog2(PATCH_SIZE + 1);
  localparam int DIM_W    = $clog2(PATCH_SIZE);
  localparam int SLOT_W   = $clog2(LEAF_SIZE);
  localparam int LEVEL_W  = $clog2(LEAF_ADDRW);
  localparam int WCNT_W   = $clog2(NUM_LEAVES * LEAF_WORDS + 1);

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [PATCH_SIZE-1:0] patch_t;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_LOAD_NODES  = 4'd1,
    ST_LOAD_LEAVES = 4'd2,
    ST_LOAD_QUERY  = 4'd3,
    ST_TRAVERSE    = 4'd4,
    ST_SCAN        = 4'd5,
    ST_WRITE       = 4'd6,
    ST_DONE        = 4'd7,
    ST_SEND        = 4'd8
  } state_e;

  function automatic elem_t abs_diff(input elem_t a, input elem_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ann_l2_dist.sv
// Combinational squared L2 distance between two patches.
module ann_l2_dist
  import ann_pkg::*;
(
  input  patch_t                i_a,
  input  patch_t                i_b,
  output logic [DIST_WIDTH-1:0] o_dist
);

  logic [DIST_WIDTH-1:0] w_diff;

  always_comb begin
    o_dist = '0;
    w_diff = '0;
    for (int i = 0; i < PATCH_SIZE; i++) begin
      w_diff = DIST_WIDTH'(abs_diff(i_a[i], i_b[i]));
      o_dist = o_dist + w_diff * w_diff;
    end
  end

endmodule

// File: rtl/ann_top.sv
// kd-tree ANN engine: load tree/leaves/queries, descend and scan per query, stream results.
// Optional leaf-id readback is built when ANN_DEBUG_EN is defined.
//
// state          | meaning
// ST_IDLE        | waiting; fsm_start honoured once a full load has completed
// ST_LOAD_NODES  | accepting (dim, median) pairs for internal nodes
// ST_LOAD_LEAVES | accepting leaf patches, each followed by its index word
// ST_LOAD_QUERY  | accepting query patches
// ST_TRAVERSE    | one tree level per cycle for the current query
// ST_SCAN        | one leaf slot per cycle, tracking the minimum distance
// ST_WRITE       | commit best index for the current query
// ST_DONE        | search finished, fsm_done high
// ST_SEND        | show-ahead result stream
module ann_top
  import ann_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_kdtree,
  input  logic                  fsm_start,
  output logic                  fsm_done,
  input  logic                  send_best_arr,
  input  logic                  in_fifo_wenq,
  input  logic [DATA_WIDTH-1:0] in_fifo_wdata,
  output logic                  in_fifo_wfull_n,
  input  logic                  out_fifo_deq,
  output logic [DATA_WIDTH-1:0] out_fifo_rdata,
  output logic                  out_fifo_rempty_n,
  input  logic                  wbs_debug
);

  logic [DIM_W-1:0]     r_node_dim [NUM_NODES];
  elem_t                r_node_med [NUM_NODES];
  patch_t               r_leaf_mem [NUM_PATCHES];
  logic [IDX_WIDTH-1:0] r_leaf_idx [NUM_PATCHES];
  patch_t               r_query_mem [NUM_QUERYS];
  logic [IDX_WIDTH-1:0] r_result [NUM_QUERYS];
`ifdef ANN_DEBUG_EN
  logic [LEAF_ADDRW-1:0] r_result_leaf [NUM_QUERYS];
`endif

  state_e                r_state;
  logic [MAJOR_W-1:0]    r_major;
  logic [MINOR_W-1:0]    r_minor;
  logic [WCNT_W-1:0]     r_words_left;
  logic                  r_loaded;
  logic                  r_done;
  logic [NODE_AW-1:0]    r_node;
  logic [LEVEL_W-1:0]    r_level;
  logic [LEAF_ADDRW-1:0] r_leaf;
  logic [SLOT_W-1:0]     r_slot;
  logic [DIST_WIDTH-1:0] r_best_dist;
  logic [IDX_WIDTH-1:0]  r_best_idx;
  logic [QIDX_W-1:0]     r_q;
  logic [QIDX_W-1:0]     r_rptr;

  logic                  w_accept;
  logic                  w_wr;
  logic [MINOR_W-1:0]    w_minor_last;
  patch_t                w_qpatch;
  patch_t                w_cand;
  logic [DIM_W-1:0]      w_dim;
  elem_t                 w_med;
  logic                  w_go_left;
  logic [NODE_W-1:0]     w_next_node;
  logic [LEAF_ADDRW-1:0] w_leaf_id;
  logic [PATCH_AW-1:0]   w_scan_addr;
  logic [DIST_WIDTH-1:0] w_dist;
  logic                  w_take;
  logic [DATA_WIDTH-1:0] w_rdata;
`ifndef ANN_DEBUG_EN
  logic                  w_unused_debug;
  assign w_unused_debug = wbs_debug;
`endif

  assign in_fifo_wfull_n   = (r_state == ST_LOAD_NODES) || (r_state == ST_LOAD_LEAVES) ||
                             (r_state == ST_LOAD_QUERY);
  assign out_fifo_rempty_n = (r_state == ST_SEND);
  assign fsm_done          = r_done;
  assign out_fifo_rdata    = w_rdata;

  assign w_accept = in_fifo_wenq && in_fifo_wfull_n;
  // a restart pulse wins over a word offered in the same cycle
  assign w_wr     = w_accept && !load_kdtree;

  always_comb begin
    w_minor_last = MINOR_W'(PATCH_SIZE - 1);
    if (r_state == ST_LOAD_NODES)       w_minor_last = MINOR_W'(1);
    else if (r_state == ST_LOAD_LEAVES) w_minor_last = MINOR_W'(PATCH_SIZE);
  end

  assign w_qpatch    = r_query_mem[r_q];
  assign w_dim       = r_node_dim[r_node];
  assign w_med       = r_node_med[r_node];
  assign w_go_left   = w_qpatch[w_dim] < w_med;
  assign w_next_node = {r_node, 1'b0} + (w_go_left ? NODE_W'(1) : NODE_W'(2));
  assign w_leaf_id   = LEAF_ADDRW'(w_next_node - NODE_W'(NUM_NODES));

  assign w_scan_addr = {r_leaf, r_slot};
  assign w_cand      = r_leaf_mem[w_scan_addr];
  assign w_take      = (r_slot == '0) || (w_dist < r_best_dist);

  ann_l2_dist u_dist (
    .i_a    (w_qpatch),
    .i_b    (w_cand),
    .o_dist (w_dist)
  );

  always_comb begin
    w_rdata = '0;
    if (r_state == ST_SEND) begin
`ifdef ANN_DEBUG_EN
      if (wbs_debug) w_rdata = DATA_WIDTH'(r_result_leaf[r_rptr]);
      else           w_rdata = DATA_WIDTH'(r_result[r_rptr]);
`else
      w_rdata = DATA_WIDTH'(r_result[r_rptr]);
`endif
    end
  end

  // storage has no reset; contents persist across reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      case (r_state)
        ST_LOAD_NODES: begin
          if (r_minor == '0) r_node_dim[r_major[NODE_AW-1:0]] <= in_fifo_wdata[DIM_W-1:0];
          else               r_node_med[r_major[NODE_AW-1:0]] <= in_fifo_wdata;
        end
        ST_LOAD_LEAVES: begin
          if (r_minor == MINOR_W'(PATCH_SIZE))
            r_leaf_idx[r_major[PATCH_AW-1:0]] <= in_fifo_wdata[IDX_WIDTH-1:0];
          else
            r_leaf_mem[r_major[PATCH_AW-1:0]][r_minor[DIM_W-1:0]] <= in_fifo_wdata;
        end
        ST_LOAD_QUERY:
          r_query_mem[r_major[QIDX_W-1:0]][r_minor[DIM_W-1:0]] <= in_fifo_wdata;
        default: ;
      endcase
    end
    if (r_state == ST_WRITE) begin
      r_result[r_q] <= r_best_idx;
`ifdef ANN_DEBUG_EN
      r_result_leaf[r_q] <= r_leaf;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_major      <= '0;
      r_minor      <= '0;
      r_words_left <= '0;
      r_loaded     <= 1'b0;
      r_done       <= 1'b0;
      r_node       <= '0;
      r_level      <= '0;
      r_leaf       <= '0;
      r_slot       <= '0;
      r_best_dist  <= '0;
      r_best_idx   <= '0;
      r_q          <= '0;
      r_rptr       <= '0;
    end else if (load_kdtree) begin
      r_state      <= ST_LOAD_NODES;
      r_major      <= '0;
      r_minor      <= '0;
      r_words_left <= WCNT_W'(NUM_NODES * 2);
      r_loaded     <= 1'b0;
      r_done       <= 1'b0;
      r_node       <= '0;
      r_level      <= '0;
      r_slot       <= '0;
      r_q          <= '0;
      r_rptr       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fsm_start && r_loaded) begin
            r_done  <= 1'b0;
            r_q     <= '0;
            r_node  <= '0;
            r_level <= LEVEL_W'(LEAF_ADDRW - 1);
            r_state <= ST_TRAVERSE;
          end
        end
        ST_LOAD_NODES, ST_LOAD_LEAVES, ST_LOAD_QUERY: begin
          if (w_accept) begin
            if (r_words_left == WCNT_W'(1)) begin
              r_major <= '0;
              r_minor <= '0;
              case (r_state)
                ST_LOAD_NODES: begin
                  r_state      <= ST_LOAD_LEAVES;
                  r_words_left <= WCNT_W'(NUM_LEAVES * LEAF_WORDS);
                end
                ST_LOAD_LEAVES: begin
                  r_state      <= ST_LOAD_QUERY;
                  r_words_left <= WCNT_W'(QUERY_WORDS);
                end
                default: begin
                  r_state  <= ST_IDLE;
                  r_loaded <= 1'b1;
                end
              endcase
            end else begin
              r_words_left <= r_words_left - WCNT_W'(1);
              if (r_minor == w_minor_last) begin
                r_minor <= '0;
                r_major <= r_major + MAJOR_W'(1);
              end else begin
                r_minor <= r_minor + MINOR_W'(1);
              end
            end
          end
        end
        ST_TRAVERSE: begin
          r_node <= w_next_node[NODE_AW-1:0];
          if (r_level == '0) begin
            r_leaf  <= w_leaf_id;
            r_slot  <= '0;
            r_state <= ST_SCAN;
          end else begin
            r_level <= r_level - LEVEL_W'(1);
          end
        end
        ST_SCAN: begin
          // strict compare keeps the lowest slot on ties
          if (w_take) begin
            r_best_dist <= w_dist;
            r_best_idx  <= r_leaf_idx[w_scan_addr];
          end
          if (r_slot == SLOT_W'(LEAF_SIZE - 1)) r_state <= ST_WRITE;
          else                                  r_slot  <= r_slot + SLOT_W'(1);
        end
        ST_WRITE: begin
          if (r_q == QIDX_W'(NUM_QUERYS - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_q     <= r_q + QIDX_W'(1);
            r_node  <= '0;
            r_level <= LEVEL_W'(LEAF_ADDRW - 1);
            r_state <= ST_TRAVERSE;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
          if (send_best_arr) begin
            r_rptr  <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_fifo_deq) begin
            if (r_rptr == QIDX_W'(NUM_QUERYS - 1)) r_state <= ST_DONE;
            else                                   r_rptr  <= r_rptr + QIDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_top.sv
// Directed bench for ann_top: three load/search/send runs with hand-built trees and leaves.
module tb_ann_top;

  localparam int NQ = 494;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_kdtree = 1'b0;
  logic        fsm_start = 1'b0;
  logic        fsm_done;
  logic        send_best_arr = 1'b0;
  logic        in_fifo_wenq = 1'b0;
  logic [10:0] in_fifo_wdata = '0;
  logic        in_fifo_wfull_n;
  logic        out_fifo_deq = 1'b0;
  logic [10:0] out_fifo_rdata;
  logic        out_fifo_rempty_n;
  logic        wbs_debug = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  ann_top dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_kdtree       (load_kdtree),
    .fsm_start         (fsm_start),
    .fsm_done          (fsm_done),
    .send_best_arr     (send_best_arr),
    .in_fifo_wenq      (in_fifo_wenq),
    .in_fifo_wdata     (in_fifo_wdata),
    .in_fifo_wfull_n   (in_fifo_wfull_n),
    .out_fifo_deq      (out_fifo_deq),
    .out_fifo_rdata    (out_fifo_rdata),
    .out_fifo_rempty_n (out_fifo_rempty_n),
    .wbs_debug         (wbs_debug)
  );

  always #5 clk = ~clk;

  // run 1/2: dim 0, median 1023 (left everywhere); run 3: dim 4, median 5 (right everywhere)
  function automatic logic [10:0] f_node_dim(input int run);
    return (run == 3) ? 11'd4 : 11'd0;
  endfunction

  function automatic logic [10:0] f_node_med(input int run);
    return (run == 3) ? 11'd5 : 11'd1023;
  endfunction

  function automatic logic [10:0] f_leaf_elem(input int run, input int p, input int e);
    if (run == 1 && p < 8) return 11'((p != 3 && e == 0) ? p * 10 + 5 : e * 100);
    if (run == 2 && p < 8) begin
      case (p)
        2:       return 11'((e == 1) ? 101 : e * 100);
        5:       return 11'((e == 1) ? 99 : e * 100);
        6:       return 11'((e == 4) ? 500 : e * 100);
        default: return 11'((e == 0) ? 50 + p : 600);
      endcase
    end
    if (run == 3 && p >= 504) begin
      if (p == 508) return 11'((e == 4) ? 500 : e * 11);
      return 11'((e == 0) ? 600 + (p - 504) : 600);
    end
    return 11'((p * 3 + e * 17) % 2048);
  endfunction

  // upper bits above the 9-bit index are set on purpose; they must be discarded
  function automatic logic [10:0] f_leaf_idx(input int run, input int p);
    if (run == 1 && p == 3) return 11'(77 + 1536);
    if (run == 2 && p < 8) return 11'(200 + 3 * p);
    if (run == 3 && p == 508) return 11'(333 + 1024);
    return 11'(p + 1024);
  endfunction

  function automatic logic [10:0] f_query_elem(input int run, input int q, input int e);
    if (run == 3) return 11'((e == 4) ? 500 : e * 11);
    if (run == 2 && (q % 2) == 1 && e == 4) return 11'd500;
    return 11'(e * 100);
  endfunction

  function automatic logic [10:0] f_expect(input int run, input int q);
    if (run == 1) return 11'd77;
    if (run == 2) return ((q % 2) == 0) ? 11'd206 : 11'd218;
    return 11'd333;
  endfunction

  task automatic send_word(input logic [10:0] w);
    in_fifo_wenq  = 1'b1;
    in_fifo_wdata = w;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (fsm_done !== 1'b0 || in_fifo_wfull_n !== 1'b0 || out_fifo_rempty_n !== 1'b0 ||
        out_fifo_rdata !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_held: done=%b wfull_n=%b rempty_n=%b rdata=%0d, required 0 0 0 0",
               fsm_done, in_fifo_wfull_n, out_fifo_rempty_n, out_fifo_rdata);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    n_checks++;
    if (fsm_done !== 1'b0 || in_fifo_wfull_n !== 1'b0 || out_fifo_rempty_n !== 1'b0 ||
        out_fifo_rdata !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_release: done=%b wfull_n=%b rempty_n=%b rdata=%0d, required 0 0 0 0",
               fsm_done, in_fifo_wfull_n, out_fifo_rempty_n, out_fifo_rdata);
    end
    @(negedge clk);
  endtask

  task automatic do_load(input int run, input bit early);
    @(negedge clk) load_kdtree = 1'b1;
    @(negedge clk) load_kdtree = 1'b0;
    n_checks++;
    if (in_fifo_wfull_n !== 1'b1 || fsm_done !== 1'b0) begin
      n_errors++;
      $display("FAIL load_start run%0d: wfull_n=%b done=%b, required 1 0",
               run, in_fifo_wfull_n, fsm_done);
    end
    for (int n = 0; n < 63; n++) begin
      send_word(f_node_dim(run));
      send_word(f_node_med(run));
    end
    for (int p = 0; p < 512; p++) begin
      for (int e = 0; e < 5; e++) send_word(f_leaf_elem(run, p, e));
      send_word(f_leaf_idx(run, p));
    end
    for (int q = 0; q < NQ; q++) begin
      for (int e = 0; e < 5; e++) begin
        if (early && q == 200 && e == 0) fsm_start = 1'b1;
        send_word(f_query_elem(run, q, e));
        fsm_start = 1'b0;
        if (early && q == 200 && e == 4) begin
          n_checks++;
          if (in_fifo_wfull_n !== 1'b1 || fsm_done !== 1'b0) begin
            n_errors++;
            $display("FAIL early_start_ignored: wfull_n=%b done=%b, required 1 0",
                     in_fifo_wfull_n, fsm_done);
          end
        end
      end
    end
    in_fifo_wenq = 1'b0;
    n_checks++;
    if (in_fifo_wfull_n !== 1'b0) begin
      n_errors++;
      $display("FAIL load_end run%0d: wfull_n=%b, required 0", run, in_fifo_wfull_n);
    end
  endtask

  task automatic run_search(input int run);
    int cnt;
    cnt = 0;
    @(negedge clk) fsm_start = 1'b1;
    @(negedge clk) fsm_start = 1'b0;
    n_checks++;
    if (fsm_done !== 1'b0) begin
      n_errors++;
      $display("FAIL done_after_start run%0d: done=%b, required 0", run, fsm_done);
    end
    while (fsm_done !== 1'b1 && cnt < 8000) begin
      @(posedge clk) #1;
      cnt++;
    end
    n_checks++;
    if (cnt != 7411) begin
      n_errors++;
      $display("FAIL done_latency run%0d: cycles=%0d, required 7411", run, cnt);
    end
    @(negedge clk);
  endtask

  task automatic send_stream(input int run, input bit hold, input bit dbg);
    logic [10:0] exp_v;
    logic [10:0] exp_dbg;
    n_checks++;
    if (out_fifo_rempty_n !== 1'b0) begin
      n_errors++;
      $display("FAIL rempty_before_send run%0d: rempty_n=%b, required 0", run, out_fifo_rempty_n);
    end
    @(negedge clk) send_best_arr = 1'b1;
    @(negedge clk) send_best_arr = 1'b0;
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (out_fifo_rempty_n !== 1'b1 || out_fifo_rdata !== f_expect(run, 0)) begin
          n_errors++;
          $display("FAIL deq_hold cycle%0d: rempty_n=%b rdata=%0d, required 1 %0d",
                   i, out_fifo_rempty_n, out_fifo_rdata, f_expect(run, 0));
        end
        @(negedge clk);
      end
    end
    for (int r = 0; r < NQ; r++) begin
      exp_v = f_expect(run, r);
      if (dbg) begin
`ifdef ANN_DEBUG_EN
        exp_dbg = 11'd63;
`else
        exp_dbg = exp_v;
`endif
        wbs_debug = 1'b1;
        #1;
        n_checks++;
        if (out_fifo_rdata !== exp_dbg) begin
          n_errors++;
          $display("FAIL debug_rdata run%0d r=%0d: rdata=%0d, required %0d",
                   run, r, out_fifo_rdata, exp_dbg);
        end
        wbs_debug = 1'b0;
        #1;
      end
      n_checks++;
      if (out_fifo_rempty_n !== 1'b1 || out_fifo_rdata !== exp_v) begin
        n_errors++;
        $display("FAIL result run%0d r=%0d: rempty_n=%b rdata=%0d, required 1 %0d",
                 run, r, out_fifo_rempty_n, out_fifo_rdata, exp_v);
      end
      out_fifo_deq = 1'b1;
      @(negedge clk) out_fifo_deq = 1'b0;
    end
    n_checks++;
    if (out_fifo_rempty_n !== 1'b0 || fsm_done !== 1'b1) begin
      n_errors++;
      $display("FAIL stream_end run%0d: rempty_n=%b done=%b, required 0 1",
               run, out_fifo_rempty_n, fsm_done);
    end
    out_fifo_deq = 1'b1;
    @(negedge clk) out_fifo_deq = 1'b0;
    n_checks++;
    if (out_fifo_rempty_n !== 1'b0) begin
      n_errors++;
      $display("FAIL deq_outside_send run%0d: rempty_n=%b, required 0", run, out_fifo_rempty_n);
    end
  endtask

  task automatic test_reset_mid_send;
    @(negedge clk) send_best_arr = 1'b1;
    @(negedge clk) send_best_arr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_fifo_deq = 1'b1;
      @(negedge clk) out_fifo_deq = 1'b0;
    end
    n_checks++;
    if (out_fifo_rempty_n !== 1'b1 || out_fifo_rdata !== 11'd77) begin
      n_errors++;
      $display("FAIL resend: rempty_n=%b rdata=%0d, required 1 77", out_fifo_rempty_n, out_fifo_rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (fsm_done !== 1'b0 || in_fifo_wfull_n !== 1'b0 || out_fifo_rempty_n !== 1'b0 ||
        out_fifo_rdata !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_mid_send: done=%b wfull_n=%b rempty_n=%b rdata=%0d, required 0 0 0 0",
               fsm_done, in_fifo_wfull_n, out_fifo_rempty_n, out_fifo_rdata);
    end
    @(negedge clk) rst_n = 1'b1;
    send_best_arr = 1'b1;
    @(negedge clk) send_best_arr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_fifo_rempty_n !== 1'b0 || fsm_done !== 1'b0) begin
      n_errors++;
      $display("FAIL send_after_reset: rempty_n=%b done=%b, required 0 0",
               out_fifo_rempty_n, fsm_done);
    end
  endtask

  task automatic test_route_left;
    do_load(1, 1'b0);
    run_search(1);
    send_stream(1, 1'b0, 1'b0);
    test_reset_mid_send();
  endtask

  task automatic test_tie_and_hold;
    do_load(2, 1'b1);
    run_search(2);
    send_stream(2, 1'b1, 1'b0);
  endtask

  task automatic test_route_right;
    do_load(3, 1'b0);
    run_search(3);
    send_stream(3, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_route_left();
    test_tie_and_hold();
    test_route_right();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ann_top.md
# ann_top

Single-clock approximate-nearest-neighbour engine, used as the top-level compute block of the patch-matching accelerator. A host streams in three things over an 11-bit write port: a complete kd-tree (internal nodes, then leaves) and a set of query patches. On start, each query descends the tree to one leaf and searches that leaf exhaustively for the minimum-L2 patch. The best patch indices are then streamed back through a show-ahead read port.

## Interface
- DATA_WIDTH, 11, width of every stream word and every patch element.
- DIST_WIDTH, 25, squared-distance accumulator width.
- IDX_WIDTH, 9, width of a stored patch index.
- LEAF_SIZE, 8, patches per leaf.
- PATCH_SIZE, 5, elements per patch.
- NUM_QUERYS, 494, number of query patches.
- NUM_LEAVES, 64, number of leaves (power of two); NUM_NODES = NUM_LEAVES-1.
- LEAF_ADDRW, 6, $clog2(NUM_LEAVES), which is also the tree depth.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_kdtree  in  1  one-cycle pulse that starts a new load sequence.
- fsm_start  in  1  one-cycle pulse that starts the search.
- fsm_done  out  1  search complete (level).
- send_best_arr  in  1  one-cycle pulse that starts the result stream.
- in_fifo_wenq  in  1  write strobe.
- in_fifo_wdata  in  DATA_WIDTH  write data.
- in_fifo_wfull_n  out  1  write ready.
- out_fifo_deq  in  1  pops the current result.
- out_fifo_rdata  out  DATA_WIDTH  current result (show-ahead).
- out_fifo_rempty_n  out  1  result valid.
- wbs_debug  in  1  debug select (see Configuration).

## Operation
- States: IDLE, LOAD_NODES, LOAD_LEAVES, LOAD_QUERY, TRAVERSE, SCAN, WRITE, DONE, SEND.
- load_kdtree in any state clears all counters and fsm_done, then enters LOAD_NODES. It overrides every other input in the same cycle.
- A word is accepted when in_fifo_wenq && in_fifo_wfull_n. in_fifo_wfull_n=1 only in the LOAD_* states; words offered in any other state are dropped.
- LOAD_NODES takes NUM_NODES*2 words. For node n (heap order: root 0, children 2n+1 and 2n+2) the words arrive as the split dimension (0..PATCH_SIZE-1), then the unsigned median.
- LOAD_LEAVES takes NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) words. They are ordered leaf-major, then patch; each patch is PATCH_SIZE elements followed by its index (low IDX_WIDTH bits kept).
- LOAD_QUERY takes NUM_QUERYS*PATCH_SIZE words, query-major. After the last word the FSM enters IDLE and sets loaded=1.
- fsm_start is honoured only in IDLE with loaded=1; otherwise it is ignored. It clears fsm_done and enters TRAVERSE with query q=0.
- TRAVERSE: one tree level per cycle. The query goes left if query[dim] < median, else right. After LEAF_ADDRW cycles, leaf = node - NUM_NODES.
- SCAN: one leaf patch per cycle, for LEAF_SIZE cycles.
  - Distance is the unsigned sum over elements of (a-b)^2, computed at DIST_WIDTH bits with no overflow at the defaults.
  - The best candidate updates only on a strictly smaller distance, so ties keep the lowest slot.
- WRITE: stores the best index (and the leaf id) for query q, then increments q. After the last query it enters DONE.
- DONE: fsm_done=1 and stays high until the next load_kdtree or fsm_start. send_best_arr in DONE enters SEND with read pointer r=0.
- SEND: out_fifo_rempty_n=1 and out_fifo_rdata = result[r], zero-extended, in raster query order. out_fifo_deq increments r. After result NUM_QUERYS-1 is popped, rempty_n falls and the FSM returns to DONE.
- out_fifo_deq outside SEND is ignored.
- Memories are not cleared by reset.

## Timing
- Reset values: fsm_done=0, in_fifo_wfull_n=0, out_fifo_rempty_n=0, out_fifo_rdata=0, state IDLE, loaded=0.
- in_fifo_wfull_n goes to 1 the cycle after the load_kdtree edge is sampled. One word is accepted per cycle, with no backpressure inside a phase.
- Per query: LEAF_ADDRW + LEAF_SIZE + 1 cycles, i.e. 15 at the defaults.
- fsm_done rises NUM_QUERYS*15 + 1 cycles after the fsm_start edge (7411 at the defaults).
- out_fifo_rdata is valid the cycle after send_best_arr. The next value appears on the cycle after each accepted deq.
- Reset asserted mid-load, mid-search or mid-send aborts immediately to the reset values.

## Configuration
- ANN_DEBUG_EN defined: while wbs_debug=1 in SEND, out_fifo_rdata carries the leaf id of result[r] (LEAF_ADDRW bits, zero-extended) instead of the best index.
- ANN_DEBUG_EN undefined: wbs_debug is ignored and per-query leaf-id storage is not built.

## Structure
- Package ann_pkg holds:
  - the state enum;
  - derived constants NUM_NODES, LEAF_WORDS = LEAF_SIZE*(PATCH_SIZE+1), QUERY_WORDS = NUM_QUERYS*PATCH_SIZE;
  - the patch-element array typedef.
- Sub-module ann_l2_dist: combinational squared L2 distance between two PATCH_SIZE-element patches, producing a DIST_WIDTH result.

## Test plan
- Reset, then poll outputs -> fsm_done=0, wfull_n=0, rempty_n=0, rdata=0.
- All medians 1023 with dim 0, and queries with element 0 = 0 -> every query reaches leaf 0.
  - Leaf 0 slot 3 equals the query with index 77 -> all results are 77, and fsm_done rises 7411 cycles after fsm_start.
- Leaf holds two patches at equal distance (slots 2 and 5) -> the reported result is slot 2's index.
- fsm_start pulsed before the query load completes -> ignored; fsm_done stays 0 and the FSM remains in the load state.
- During SEND, deq held low for 10 cycles and then pulsed -> rdata holds result[0] throughout, then shows result[1].
- Under ANN_DEBUG_EN, wbs_debug=1 in SEND with every query routed right at every level -> rdata=63 for every result.
